// File: rtl/fwd_hazard_ctrl_if.sv
// Operand-select bus between the ID stage and the forwarding/hazard controller.
interface fwd_hazard_ctrl_if #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
);
    logic             id_valid;
    logic             id_ready;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_rs2_used;
    logic [REG_W-1:0] id_rd;
    logic             id_reg_wen;
    logic             id_is_load;
    logic             id_use_pc;
    logic             id_use_imm;
    logic             id_br_unsigned;
    logic             flush;
    logic             ex_valid;
    logic             A1_sel;
    logic             B1_sel;
    logic             A2_sel;
    logic             B2_sel;
    logic             Brun;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] fwd_cnt;

    // ID/decode side
    modport master (
        output id_valid, id_rs1, id_rs2, id_rs2_used, id_rd, id_reg_wen,
               id_is_load, id_use_pc, id_use_imm, id_br_unsigned, flush,
        input  id_ready, ex_valid, A1_sel, B1_sel, A2_sel, B2_sel, Brun,
               stall_cnt, fwd_cnt
    );

    // Controller side
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs2_used, id_rd, id_reg_wen,
               id_is_load, id_use_pc, id_use_imm, id_br_unsigned, flush,
        output id_ready, ex_valid, A1_sel, B1_sel, A2_sel, B2_sel, Brun,
               stall_cnt, fwd_cnt
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for a 3-stage RV32I pipeline.
// Optional statistics counters are enabled by defining FWD_STATS_EN.
module fwd_hazard_ctrl #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    fwd_hazard_ctrl_if.slave   bus
);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             wen;
        logic             load;
        logic             a1_sel;
        logic             b1_sel;
        logic             a2_sel;
        logic             b2_sel;
        logic             brun;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '0;

    slot_t slot_q;
    slot_t slot_d;
    logic  ex_writer;
    logic  dep1;
    logic  dep2;
    logic  hazard;
    logic  accept;

    // Dependency against the instruction currently in EX; x0 never forwards
    always_comb begin
        ex_writer = slot_q.valid & slot_q.wen & (slot_q.rd != REG_W'(0));
        dep1      = ex_writer & (bus.id_rs1 == slot_q.rd) & ~bus.id_use_pc;
        dep2      = ex_writer & (bus.id_rs2 == slot_q.rd) & bus.id_rs2_used;
        hazard    = bus.id_valid & slot_q.load & (dep1 | dep2) & ~bus.flush;
        accept    = bus.id_valid & ~bus.flush & ~hazard;
    end

    assign bus.id_ready = ~rst & ~hazard;

    // Next EX slot: flush, hazard and idle all collapse to a bubble
    always_comb begin
        slot_d = SLOT_BUBBLE;
        if (accept) begin
            slot_d.valid  = 1'b1;
            slot_d.rd     = bus.id_rd;
            slot_d.wen    = bus.id_reg_wen;
            slot_d.load   = bus.id_is_load;
            slot_d.a1_sel = dep1;
            slot_d.b1_sel = dep2;
            slot_d.a2_sel = bus.id_use_pc;
            slot_d.b2_sel = bus.id_use_imm;
            slot_d.brun   = bus.id_br_unsigned;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= SLOT_BUBBLE;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign bus.ex_valid = slot_q.valid;
    assign bus.A1_sel   = slot_q.a1_sel;
    assign bus.B1_sel   = slot_q.b1_sel;
    assign bus.A2_sel   = slot_q.a2_sel;
    assign bus.B2_sel   = slot_q.b2_sel;
    assign bus.Brun     = slot_q.brun;

`ifdef FWD_STATS_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] fwd_q;
    logic             fwd_hit;

    assign fwd_hit = accept & (dep1 | dep2) & ~slot_q.load;

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= CNT_W'(0);
            fwd_q   <= CNT_W'(0);
        end else begin
            if (hazard && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (fwd_hit && (fwd_q != {CNT_W{1'b1}})) begin
                fwd_q <= fwd_q + CNT_W'(1);
            end
        end
    end

    assign bus.stall_cnt = stall_q;
    assign bus.fwd_cnt   = fwd_q;
`else
    assign bus.stall_cnt = CNT_W'(0);
    assign bus.fwd_cnt   = CNT_W'(0);
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed scoreboard bench for fwd_hazard_ctrl; counter expectations follow FWD_STATS_EN.
module tb_fwd_hazard_ctrl;

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 16;
`ifdef FWD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        string      tag;
        logic [5:0] outs;
        int         stall;
        int         fwd;
    } exp_t;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    exp_t sb[$];

    fwd_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    fwd_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive one ID cycle, check id_ready, then check the EX outputs after the edge.
    // outs = {ex_valid, A1_sel, B1_sel, A2_sel, B2_sel, Brun}
    task automatic step(input string tag, input logic r, input logic v,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic rs2u,
                        input logic [4:0] rd, input logic wen, input logic ld,
                        input logic pc, input logic imm, input logic bu, input logic fl,
                        input logic exp_ready, input logic [5:0] exp_outs,
                        input int exp_stall, input int exp_fwd);
        exp_t e;
        exp_t got;
        rst                = r;
        bus.id_valid       = v;
        bus.id_rs1         = rs1;
        bus.id_rs2         = rs2;
        bus.id_rs2_used    = rs2u;
        bus.id_rd          = rd;
        bus.id_reg_wen     = wen;
        bus.id_is_load     = ld;
        bus.id_use_pc      = pc;
        bus.id_use_imm     = imm;
        bus.id_br_unsigned = bu;
        bus.flush          = fl;
        #1;
        chk({tag, "_ready"}, 32'(bus.id_ready), 32'(exp_ready));
        e.tag   = tag;
        e.outs  = exp_outs;
        e.stall = STATS ? exp_stall : 0;
        e.fwd   = STATS ? exp_fwd : 0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk({got.tag, "_sel"}, 32'({bus.ex_valid, bus.A1_sel, bus.B1_sel,
                                    bus.A2_sel, bus.B2_sel, bus.Brun}), 32'(got.outs));
        chk({got.tag, "_stall"}, 32'(bus.stall_cnt), 32'(got.stall));
        chk({got.tag, "_fwd"}, 32'(bus.fwd_cnt), 32'(got.fwd));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        //   tag          rst v  rs1 rs2 u  rd  w  ld pc im bu fl  rdy outs        st fw
        step("rst0",      1, 0, 0,  0,  0, 0,  0, 0, 0, 0, 0, 0,  0, 6'b000000, 0, 0);
        step("rst1",      1, 0, 0,  0,  0, 0,  0, 0, 0, 0, 0, 0,  0, 6'b000000, 0, 0);
        step("add_x5",    0, 1, 1,  2,  1, 5,  1, 0, 0, 0, 0, 0,  1, 6'b100000, 0, 0);
        step("sub_fwdA",  0, 1, 5,  3,  1, 6,  1, 0, 0, 0, 0, 0,  1, 6'b110000, 0, 1);
        step("idle",      0, 0, 0,  0,  0, 0,  0, 0, 0, 0, 0, 0,  1, 6'b000000, 0, 1);
        step("lw_x7",     0, 1, 1,  0,  0, 7,  1, 1, 0, 1, 0, 0,  1, 6'b100010, 0, 1);
        step("lu_haz",    0, 1, 2,  7,  1, 8,  1, 0, 0, 0, 0, 0,  0, 6'b000000, 1, 1);
        step("lu_retry",  0, 1, 2,  7,  1, 8,  1, 0, 0, 0, 0, 0,  1, 6'b100000, 1, 1);
        step("addi_x0",   0, 1, 1,  0,  0, 0,  1, 0, 0, 1, 0, 0,  1, 6'b100010, 1, 1);
        step("add_x0x0",  0, 1, 0,  0,  1, 9,  1, 0, 0, 0, 0, 0,  1, 6'b100000, 1, 1);
        step("addi_x5",   0, 1, 5,  0,  0, 5,  1, 0, 0, 1, 0, 0,  1, 6'b100010, 1, 1);
        step("sw_fwdB",   0, 1, 4,  5,  1, 8,  0, 0, 0, 1, 0, 0,  1, 6'b101010, 1, 2);
        step("addi_x3",   0, 1, 0,  0,  0, 3,  1, 0, 0, 1, 0, 0,  1, 6'b100010, 1, 2);
        step("auipc",     0, 1, 3,  0,  0, 10, 1, 0, 1, 1, 0, 0,  1, 6'b100110, 1, 2);
        step("lw_x7b",    0, 1, 1,  0,  0, 7,  1, 1, 0, 1, 0, 0,  1, 6'b100010, 1, 2);
        step("flush_haz", 0, 1, 2,  7,  1, 8,  1, 0, 0, 0, 0, 1,  1, 6'b000000, 1, 2);
        step("bltu",      0, 1, 3,  4,  1, 0,  0, 0, 0, 0, 1, 0,  1, 6'b100001, 1, 2);
        step("addi_x11",  0, 1, 0,  0,  0, 11, 1, 0, 0, 1, 0, 0,  1, 6'b100010, 1, 2);
        step("add_both",  0, 1, 11, 11, 1, 12, 1, 0, 0, 0, 0, 0,  1, 6'b111000, 1, 3);
        step("chain",     0, 1, 12, 11, 1, 13, 1, 0, 0, 0, 0, 0,  1, 6'b110000, 1, 4);
        step("rst_mid",   1, 1, 13, 0,  1, 14, 1, 0, 0, 0, 0, 0,  0, 6'b000000, 0, 0);
        step("post_rst",  0, 1, 13, 1,  1, 15, 1, 0, 0, 0, 0, 0,  1, 6'b100000, 0, 0);
        step("lw_x7c",    0, 1, 1,  0,  0, 7,  1, 1, 0, 1, 0, 0,  1, 6'b100010, 0, 0);
        step("lu_haz_a",  0, 1, 7,  2,  1, 16, 1, 0, 0, 0, 0, 0,  0, 6'b000000, 1, 0);
        step("lu_retry2", 0, 1, 7,  2,  1, 16, 1, 0, 0, 0, 0, 0,  1, 6'b100000, 1, 0);
        step("lw_x7d",    0, 1, 1,  0,  0, 7,  1, 1, 0, 1, 0, 0,  1, 6'b100010, 1, 0);
        step("rs2_unused",0, 1, 1,  7,  0, 17, 1, 0, 0, 1, 0, 0,  1, 6'b100010, 1, 0);
        step("idle_end",  0, 0, 0,  0,  0, 0,  0, 0, 0, 0, 0, 0,  1, 6'b000000, 1, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Forwarding and hazard controller for the operand-select datapath of the 3-stage RV32I pipeline (ID / EX / MEM-WB).
- Tracks the instruction held in EX and drives the registered select lines for that datapath:
  - A1_sel: rs1 vs. ALU forward
  - B1_sel: rs2 vs. ALU forward; this also feeds store data
  - A2_sel: A1 path vs. pc
  - B2_sel: B1 path vs. imm
  - Brun: unsigned branch compare
- Inserts a one-cycle bubble on load-use hazards and on flush.
- The regfile is write-before-read, so distance-2 dependencies need no action.

Parameters:
- REG_W, 5, register index width
- CNT_W, 16, statistics counter width (used only with FWD_STATS_EN)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- id_valid  in  1  decoded instruction present in ID
- id_ready  out  1  ID instruction accepted into EX this cycle
- id_rs1  in  REG_W  source register 1
- id_rs2  in  REG_W  source register 2
- id_rs2_used  in  1  instruction reads rs2 (R-type, branch, store)
- id_rd  in  REG_W  destination register
- id_reg_wen  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load
- id_use_pc  in  1  operand A is pc (auipc, jal)
- id_use_imm  in  1  operand B is imm
- id_br_unsigned  in  1  bltu/bgeu
- flush  in  1  taken branch/jump; kills the ID instruction
- ex_valid  out  1  EX slot holds a real instruction
- A1_sel  out  1  1 = forward alu into the A1 path
- B1_sel  out  1  1 = forward alu into the B1 path (and data_w)
- A2_sel  out  1  1 = pc
- B2_sel  out  1  1 = imm
- Brun  out  1  unsigned compare
- stall_cnt  out  CNT_W  load-use stall cycles
- fwd_cnt  out  CNT_W  instructions with at least one forward

Behaviour:
- EX slot state (registered): ex_valid, ex_rd, ex_wen, ex_load.
- Dependency flags (combinational):
  - dep1 = ex_valid & ex_wen & (ex_rd != 0) & (id_rs1 == ex_rd) & !id_use_pc
  - dep2 = ex_valid & ex_wen & (ex_rd != 0) & (id_rs2 == ex_rd) & id_rs2_used
- hazard = id_valid & ex_load & (dep1 | dep2) & !flush.
- id_ready = !rst & !hazard. The value is combinational, in the same cycle. When id_valid is 0, id_ready means only "would accept".
- Each posedge, first match wins:
  1. rst: all slot state and all outputs go to 0; counters go to 0.
  2. flush: bubble. ex_valid=0 and all selects=0. The ID instruction is discarded and its selects are not latched.
  3. hazard: bubble, same as flush. The ID instruction is held upstream and re-presented next cycle. With the load now in MEM-WB, dep1/dep2 evaluate false and the instruction enters with selects from the regfile (A1_sel=B1_sel=0).
  4. id_valid (no hazard): capture id_rd/wen/load into the slot and set ex_valid=1. Latch:
     - A1_sel = dep1
     - B1_sel = dep2
     - A2_sel = id_use_pc
     - B2_sel = id_use_imm
     - Brun = id_br_unsigned
  5. Otherwise: bubble.
- Latency: selects are valid for the whole EX cycle, one clock after ID acceptance.
- x0 is never forwarded.
- Forwarding into B1 while B2_sel=1 is legal and required: it is the store-data path.
- Back-to-back dependents: each compares only against the immediately preceding accepted instruction. Bubbles break the chain.
- Reset mid-operation discards the EX slot; there is no replay.

Optional Feature:
- FWD_STATS_EN defined:
  - stall_cnt increments on every cycle where hazard=1.
  - fwd_cnt increments on every accepted instruction with dep1|dep2 and !ex_load.
  - Both counters saturate at all-ones and clear on rst.
- Undefined: stall_cnt and fwd_cnt are tied to 0 and no counter flops are generated.

Test Plan:
- add x5,x1,x2 then sub x6,x5,x3 (no load) -> 2nd EX cycle: A1_sel=1, B1_sel=0, id_ready stays 1, no bubble; fwd_cnt=1.
- lw x7,0(x1) then add x8,x2,x7 -> id_ready=0 for 1 cycle and ex_valid=0 bubble. Next cycle: add enters with B1_sel=0, A1_sel=0; stall_cnt=1.
- addi x0,x1,4 then add x9,x0,x0 -> A1_sel=B1_sel=0 (x0 never forwarded).
- sw x5,8(x4) after addi x5,x5,1 -> B1_sel=1, B2_sel=1, A1_sel=0 (data_w forwarded); auipc x10 after writer of x10's rs1 -> A2_sel=1, A1_sel=0.
- lw x7 then dependent add, with flush asserted in the hazard cycle -> flush wins: id_ready=1, ex_valid=0 next cycle, stall_cnt unchanged.
- bltu x3,x4 -> Brun=1 in EX. Assert rst during a valid EX slot -> next cycle all outputs 0 and ex_valid=0.
